hall_commutator: RTL and testbench
==================================

Name: hall_commutator

Overview:
Parametrised six-step BLDC commutation controller, successor to the combinational hall-to-phase decoder. Synchronises and deglitches the 3-bit hall input, decodes the rotor sector, and drives complementary high/low gate enables for phases A/B/C. Supports forward and reverse direction, enable gating, programmable dead time and latched fault detection. Sits between the hall sensor pins and the gate-driver/PWM stage.

Parameters:
FILTER_LEN, 4, consecutive cycles the synchronised hall code must be stable before it is accepted (1..255).
DEADTIME, 8, cycles all gates are held off between any two different non-zero gate patterns (1..255).
CNT_W, 8, width of the filter and dead-time counters; must hold FILTER_LEN and DEADTIME.

Ports:
clk  in  1  system clock.
rst_n  in  1  synchronous active-low reset.
en  in  1  drive enable; 0 forces all gates off.
dir  in  1  0 = forward, 1 = reverse.
hall  in  3  raw asynchronous hall inputs {C,B,A}.
fault_clr  in  1  single-cycle request to clear a latched fault.
gate_h  out  3  high-side enables {C,B,A}, registered.
gate_l  out  3  low-side enables {C,B,A}, registered.
sector  out  3  accepted sector 0..5; 7 = none/invalid.
comm_pulse  out  1  one-cycle pulse on each accepted valid sector change.
fault  out  1  latched fault flag.

Behaviour:
- Reset (rst_n=0 at a clk edge): gate_h=gate_l=0, sector=7, comm_pulse=0, fault=0, state IDLE, sync flops=000, filter counter=0, no accepted code (acc_valid=0).
- Input path: 2-flop synchroniser on hall. Filter counter resets to 0 on any synchronised change; the code is accepted when the counter reaches FILTER_LEN-1 with no change, i.e. after FILTER_LEN stable cycles. Raw change at edge 0 is accepted at edge F = 2+FILTER_LEN.
- Sector map (hall -> sector): 001->0, 011->1, 010->2, 110->3, 100->4, 101->5; 000/111 invalid.
- Forward pattern (high, low): s0 A/B, s1 A/C, s2 B/C, s3 B/A, s4 C/A, s5 C/B. Reverse: same sector with high and low phases swapped.
- Fault sources, evaluated only on accepted codes: invalid code; valid code non-adjacent (mod 6) to the previous accepted valid sector. Ignored for the first valid accept after reset or fault clear. Detection sets fault=1 and sector=7.
- States: IDLE (gates 0), DEAD (gates 0, counting), DRIVE (gates = pattern), FAULT (gates 0).
- IDLE -> DEAD when en=1 and a valid sector is accepted.
- DRIVE -> DEAD when the target pattern changes (sector or dir). Gates go 0 at edge F+1; new pattern appears at edge F+1+DEADTIME.
- DEAD -> DRIVE after DEADTIME cycles, using the target latched at that edge. Target changes during DEAD do not restart the count.
- Any state -> IDLE when en=0 (gates off next edge, no dead time). Fault has priority over en.
- Any state -> FAULT on a fault source. FAULT -> IDLE on fault_clr=1 when the current accepted code is valid; fault clears the same edge. fault_clr on the same edge as a new fault source is ignored.
- gate_h & gate_l is always 000; at most one bit set in each.
- comm_pulse: high for exactly one cycle when the accepted sector changes to a valid value, including in IDLE. Not asserted on fault.

Test Plan:
- Reset, en=1, dir=0, hall=001 held -> sector=0 at edge 6; gates 0 through edge 14; gate_h=001, gate_l=010 from edge 15.
- Forward sweep 001,011,010,110,100,101, each held 40 cycles -> sectors 0..5 in order, one comm_pulse per step, gate_h/gate_l follow the table, and each step shows exactly 8 all-off cycles.
- dir toggled 0->1 in sector 2 -> 8 off cycles, then gate_h=100 (C), gate_l=010 (B); no comm_pulse.
- 2-cycle glitch 011->111->011 with FILTER_LEN=4 -> no sector change, no fault, gates steady.
- Hall jumps 001->010 (skip) -> fault=1, sector=7, gates 0; fault_clr while hall=010 -> IDLE, then DEAD (8 cycles) -> DRIVE with B/C.
- hall=000 accepted -> fault; fault_clr while still 000 -> fault stays 1. en=0 in DRIVE -> gates 0 on next edge. rst_n=0 mid-DEAD -> all outputs at reset values next edge.

Source files
------------

// File: rtl/hall_commutator.sv
// Six-step BLDC commutation controller.
// Synchronises and deglitches the raw hall code, maps it to a rotor sector,
// and drives complementary high/low gate enables with dead time between
// any two different drive patterns. Illegal or non-adjacent hall codes
// latch a fault that forces all gates off until cleared.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   en         drive enable; 0 forces all gates off
//   dir        0 = forward, 1 = reverse
//   hall       raw asynchronous hall inputs {C,B,A}
//   fault_clr  single-cycle request to clear a latched fault
//   gate_h     high-side enables {C,B,A}, registered
//   gate_l     low-side enables {C,B,A}, registered
//   sector     accepted sector 0..5, 7 = none/invalid
//   comm_pulse one-cycle pulse on each accepted valid sector change
//   fault      latched fault flag
module hall_commutator #(
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned DEADTIME   = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       dir,
  input  logic [2:0] hall,
  input  logic       fault_clr,
  output logic [2:0] gate_h,
  output logic [2:0] gate_l,
  output logic [2:0] sector,
  output logic       comm_pulse,
  output logic       fault
);

  typedef enum logic [1:0] {IDLE, DEAD, DRIVE, FAULT} state_t;

  localparam logic [CNT_W-1:0] FILT_MAX = CNT_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] DEAD_MAX = CNT_W'(DEADTIME - 1);
  localparam logic [2:0]       NO_SEC   = 3'd7;

  state_t           state;
  logic [2:0]       sync1, sync2;
  logic [2:0]       filt_code;
  logic [CNT_W-1:0] filt_cnt;
  logic [2:0]       acc_code;
  logic             acc_valid;
  logic [2:0]       last_sec;
  logic             last_valid;
  logic [CNT_W-1:0] dead_cnt;

  logic             stable;
  logic             acc_new;
  logic [2:0]       new_sec;
  logic             new_ok;
  logic [2:0]       cur_sec;
  logic             fault_src;
  logic             clear_ok;
  logic [5:0]       tgt;

  function automatic logic [2:0] hall_to_sector(input logic [2:0] h);
    logic [2:0] s;
    case (h)
      3'b001:  s = 3'd0;
      3'b011:  s = 3'd1;
      3'b010:  s = 3'd2;
      3'b110:  s = 3'd3;
      3'b100:  s = 3'd4;
      3'b101:  s = 3'd5;
      default: s = NO_SEC;
    endcase
    return s;
  endfunction

  function automatic logic is_adjacent(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] d;
    d = (a >= b) ? (a - b) : (b - a);
    return (d == 3'd1) || (d == 3'd5);
  endfunction

  // Returns {high, low}; reverse swaps the two phases of the same sector.
  function automatic logic [5:0] drive_pattern(input logic [2:0] s, input logic rev);
    logic [2:0] hi, lo;
    case (s)
      3'd0:    begin hi = 3'b001; lo = 3'b010; end
      3'd1:    begin hi = 3'b001; lo = 3'b100; end
      3'd2:    begin hi = 3'b010; lo = 3'b100; end
      3'd3:    begin hi = 3'b010; lo = 3'b001; end
      3'd4:    begin hi = 3'b100; lo = 3'b001; end
      3'd5:    begin hi = 3'b100; lo = 3'b010; end
      default: begin hi = 3'b000; lo = 3'b000; end
    endcase
    return rev ? {lo, hi} : {hi, lo};
  endfunction

  always_comb begin
    stable    = (sync2 == filt_code);
    // Accept once per stable run: the counter saturates, and a code equal
    // to the one already accepted is not treated as a new event.
    acc_new   = stable && (filt_cnt == FILT_MAX) &&
                (!acc_valid || (filt_code != acc_code));
    new_sec   = hall_to_sector(filt_code);
    new_ok    = (new_sec != NO_SEC);
    cur_sec   = acc_new ? new_sec : hall_to_sector(acc_code);
    fault_src = acc_new && (!new_ok || (last_valid && !is_adjacent(new_sec, last_sec)));
    clear_ok  = fault && fault_clr && (cur_sec != NO_SEC) && !fault_src;
    tgt       = drive_pattern(sector, dir);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sync1      <= '0;
      sync2      <= '0;
      filt_code  <= '0;
      filt_cnt   <= '0;
      acc_code   <= '0;
      acc_valid  <= 1'b0;
      last_sec   <= '0;
      last_valid <= 1'b0;
      dead_cnt   <= '0;
      gate_h     <= '0;
      gate_l     <= '0;
      sector     <= NO_SEC;
      comm_pulse <= 1'b0;
      fault      <= 1'b0;
    end else begin
      sync1 <= hall;
      sync2 <= sync1;

      if (!stable) begin
        filt_code <= sync2;
        filt_cnt  <= '0;
      end else if (filt_cnt != FILT_MAX) begin
        filt_cnt <= filt_cnt + CNT_W'(1);
      end

      if (acc_new) begin
        acc_code  <= filt_code;
        acc_valid <= 1'b1;
      end

      comm_pulse <= 1'b0;

      if (fault_src) begin
        fault      <= 1'b1;
        sector     <= NO_SEC;
        last_valid <= 1'b0;
        state      <= FAULT;
        gate_h     <= '0;
        gate_l     <= '0;
      end else begin
        if (acc_new && new_ok) begin
          last_sec   <= new_sec;
          last_valid <= 1'b1;
        end
        // Clearing restarts adjacency tracking; it overrides the update above.
        if (clear_ok) begin
          fault      <= 1'b0;
          last_valid <= 1'b0;
        end

        if (fault && !clear_ok) begin
          sector <= NO_SEC;
          state  <= FAULT;
          gate_h <= '0;
          gate_l <= '0;
        end else begin
          sector     <= cur_sec;
          comm_pulse <= acc_new && new_ok && (new_sec != sector);
          if (clear_ok || !en) begin
            state  <= IDLE;
            gate_h <= '0;
            gate_l <= '0;
          end else begin
            case (state)
              IDLE: begin
                if (sector != NO_SEC) begin
                  state    <= DEAD;
                  dead_cnt <= '0;
                end
              end
              DEAD: begin
                if (dead_cnt == DEAD_MAX) begin
                  state  <= DRIVE;
                  gate_h <= tgt[5:3];
                  gate_l <= tgt[2:0];
                end else begin
                  dead_cnt <= dead_cnt + CNT_W'(1);
                end
              end
              DRIVE: begin
                if (tgt != {gate_h, gate_l}) begin
                  state    <= DEAD;
                  dead_cnt <= '0;
                  gate_h   <= '0;
                  gate_l   <= '0;
                end
              end
              default: begin
                state  <= IDLE;
                gate_h <= '0;
                gate_l <= '0;
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hall_commutator.sv
// Bench for hall_commutator: directed scenarios followed by randomized hall,
// direction, enable and fault-clear activity, all compared every cycle with
// a reference model built from the sector/adjacency/dead-time rules.
module tb_hall_commutator;

  localparam int FILTER_LEN = 4;
  localparam int DEADTIME   = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       dir;
  logic [2:0] hall;
  logic       fault_clr;
  logic [2:0] gate_h;
  logic [2:0] gate_l;
  logic [2:0] sector;
  logic       comm_pulse;
  logic       fault;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hall_commutator #(
    .FILTER_LEN(FILTER_LEN),
    .DEADTIME  (DEADTIME),
    .CNT_W     (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .dir       (dir),
    .hall      (hall),
    .fault_clr (fault_clr),
    .gate_h    (gate_h),
    .gate_l    (gate_l),
    .sector    (sector),
    .comm_pulse(comm_pulse),
    .fault     (fault)
  );

  // Reference tables: hall code -> sector, sector -> hall code,
  // and forward (high, low) phase index per sector (0=A, 1=B, 2=C).
  int sec_map [8] = '{7, 0, 2, 1, 4, 5, 3, 7};
  int codes   [6] = '{1, 3, 2, 6, 4, 5};
  int hi_ph   [6] = '{0, 0, 1, 1, 2, 2};
  int lo_ph   [6] = '{1, 2, 2, 0, 0, 1};
  int exp_h   [6] = '{1, 1, 2, 2, 4, 4};
  int exp_l   [6] = '{2, 4, 4, 1, 1, 2};

  // Model state
  int         hist[$];
  int         m_sector, m_acc, m_last, m_dead;
  bit         m_acc_ok, m_last_ok, m_fault, m_pulse;
  logic [2:0] m_gh, m_gl;

  function automatic bit adj(input int a, input int b);
    int d;
    d = (a - b + 6) % 6;
    return (d == 1) || (d == 5);
  endfunction

  function automatic logic [5:0] tgt(input int s, input logic d);
    int h, l, tmp;
    if (s > 5) return 6'b0;
    h = hi_ph[s];
    l = lo_ph[s];
    if (d) begin tmp = h; h = l; l = tmp; end
    return {3'(1 << h), 3'(1 << l)};
  endfunction

  task automatic model_edge();
    int n, code, nsec, cur, psec;
    bit acc, nf, clr;
    logic [5:0] pg, t;
    if (!rst_n) begin
      // Synchroniser and filter start as if 000 had just arrived at this edge.
      hist = '{8, 0, 0, 0};
      m_sector = 7; m_fault = 0; m_pulse = 0; m_gh = '0; m_gl = '0;
      m_acc = 0; m_acc_ok = 0; m_last = 0; m_last_ok = 0; m_dead = 0;
      return;
    end
    hist.push_back(int'(hall));
    n = hist.size();
    acc = 0;
    code = 0;
    // A code is taken once it has been sampled FILTER_LEN+1 times in a row,
    // the newest of those samples being two edges old.
    if (n >= FILTER_LEN + 3) begin
      code = hist[n-3];
      acc = 1;
      for (int k = 0; k <= FILTER_LEN; k++)
        if (hist[n-3-k] != code) acc = 0;
      if (m_acc_ok && code == m_acc) acc = 0;
    end
    psec = m_sector;
    pg   = {m_gh, m_gl};
    nsec = sec_map[code];
    if (acc) begin m_acc = code; m_acc_ok = 1; end
    cur = m_acc_ok ? sec_map[m_acc] : 7;
    nf  = acc && (nsec == 7 || (m_last_ok && !adj(nsec, m_last)));
    clr = m_fault && fault_clr && (cur != 7) && !nf;
    m_pulse = 0;
    if (nf) begin
      m_fault = 1; m_sector = 7; m_last_ok = 0;
    end else begin
      if (acc && nsec != 7) begin m_last = nsec; m_last_ok = 1; end
      if (clr) begin m_fault = 0; m_last_ok = 0; end
      if (m_fault) m_sector = 7;
      else begin
        m_pulse  = acc && (nsec != 7) && (nsec != psec);
        m_sector = cur;
      end
    end
    t = tgt(psec, dir);
    if (m_fault || clr || !en) begin
      m_gh = '0; m_gl = '0; m_dead = 0;
    end else if (pg != 6'b0) begin
      if (t != pg) begin m_gh = '0; m_gl = '0; m_dead = 1; end
    end else if (m_dead > 0) begin
      if (m_dead == DEADTIME) begin {m_gh, m_gl} = t; m_dead = 0; end
      else m_dead++;
    end else if (psec != 7) begin
      m_dead = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("sector",  8'(sector),     8'(m_sector));
    chk("fault",   8'(fault),      8'(m_fault));
    chk("pulse",   8'(comm_pulse), 8'(m_pulse));
    chk("gate_h",  8'(gate_h),     8'(m_gh));
    chk("gate_l",  8'(gate_l),     8'(m_gl));
    chk("overlap", 8'(gate_h & gate_l), 8'd0);
  endtask

  task automatic run_seg(input int n, output int offs, output int pulses, output int gchg);
    logic [5:0] prev;
    offs = 0; pulses = 0; gchg = 0;
    prev = {gate_h, gate_l};
    for (int i = 0; i < n; i++) begin
      tick();
      if (gate_h == 3'b0 && gate_l == 3'b0) offs++;
      if (comm_pulse) pulses++;
      if ({gate_h, gate_l} != prev) gchg++;
      prev = {gate_h, gate_l};
    end
  endtask

  initial begin
    int offs, pulses, gchg, s;
    logic [2:0] h;

    // Reset with hall=001 held, then release
    rst_n = 1'b0; en = 1'b1; dir = 1'b0; hall = 3'b001; fault_clr = 1'b0;
    repeat (3) tick();
    chk("rst_sector", 8'(sector), 8'd7);
    chk("rst_gates",  8'({gate_h, gate_l}), 8'd0);
    chk("rst_fault",  8'(fault), 8'd0);
    rst_n = 1'b1;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (e == 5)  chk("s0_not_yet", 8'(sector), 8'd7);
      if (e == 6)  begin chk("s0_accept", 8'(sector), 8'd0); chk("s0_pulse", 8'(comm_pulse), 8'd1); end
      if (e == 14) chk("s0_dead_end", 8'({gate_h, gate_l}), 8'd0);
      if (e == 15) begin chk("s0_gate_h", 8'(gate_h), 8'b001); chk("s0_gate_l", 8'(gate_l), 8'b010); end
    end

    // Forward sweep
    for (int k = 1; k < 6; k++) begin
      hall = 3'(codes[k]);
      run_seg(40, offs, pulses, gchg);
      chk("sweep_sector", 8'(sector), 8'(k));
      chk("sweep_offs",   8'(offs),   8'(DEADTIME));
      chk("sweep_pulses", 8'(pulses), 8'd1);
      chk("sweep_gate_h", 8'(gate_h), 8'(exp_h[k]));
      chk("sweep_gate_l", 8'(gate_l), 8'(exp_l[k]));
    end

    // Walk back to sector 2 and reverse direction there
    for (int k = 4; k >= 2; k--) begin
      hall = 3'(codes[k]);
      run_seg(40, offs, pulses, gchg);
    end
    dir = 1'b1;
    run_seg(40, offs, pulses, gchg);
    chk("rev_offs",   8'(offs),   8'(DEADTIME));
    chk("rev_pulses", 8'(pulses), 8'd0);
    chk("rev_gate_h", 8'(gate_h), 8'b100);
    chk("rev_gate_l", 8'(gate_l), 8'b010);
    dir = 1'b0;
    run_seg(40, offs, pulses, gchg);

    // Short glitch in sector 1
    hall = 3'b011;
    run_seg(40, offs, pulses, gchg);
    hall = 3'b111;
    run_seg(2, offs, pulses, gchg);
    hall = 3'b011;
    run_seg(40, offs, pulses, gchg);
    chk("glitch_pulses", 8'(pulses), 8'd0);
    chk("glitch_gchg",   8'(gchg),   8'd0);
    chk("glitch_fault",  8'(fault),  8'd0);
    chk("glitch_sector", 8'(sector), 8'd1);

    // Skipped sector 0 -> 2, then clear while on 010
    hall = 3'b001;
    run_seg(40, offs, pulses, gchg);
    hall = 3'b010;
    run_seg(40, offs, pulses, gchg);
    chk("skip_fault",  8'(fault),  8'd1);
    chk("skip_sector", 8'(sector), 8'd7);
    chk("skip_gates",  8'({gate_h, gate_l}), 8'd0);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("clr_fault", 8'(fault), 8'd0);
    run_seg(30, offs, pulses, gchg);
    chk("clr_offs",   8'(offs),   8'(DEADTIME));
    chk("clr_gate_h", 8'(gate_h), 8'b010);
    chk("clr_gate_l", 8'(gate_l), 8'b100);

    // Invalid 000; clearing while still invalid must not clear
    hall = 3'b000;
    run_seg(40, offs, pulses, gchg);
    chk("inv_fault", 8'(fault), 8'd1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("inv_clr_fault", 8'(fault), 8'd1);

    // Recover on 001, then drop enable while driving
    hall = 3'b001;
    run_seg(40, offs, pulses, gchg);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    run_seg(20, offs, pulses, gchg);
    chk("rec_gate_h", 8'(gate_h), 8'b001);
    chk("rec_gate_l", 8'(gate_l), 8'b010);
    en = 1'b0;
    tick();
    chk("en_off_gates", 8'({gate_h, gate_l}), 8'd0);
    en = 1'b1;
    run_seg(20, offs, pulses, gchg);

    // Reset in the middle of dead time
    hall = 3'b011;
    run_seg(9, offs, pulses, gchg);
    chk("mid_dead_gates", 8'({gate_h, gate_l}), 8'd0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_sector", 8'(sector), 8'd7);
    chk("mid_rst_gates",  8'({gate_h, gate_l}), 8'd0);
    chk("mid_rst_pulse",  8'(comm_pulse), 8'd0);
    chk("mid_rst_fault",  8'(fault), 8'd0);
    rst_n = 1'b1;

    // Randomized activity
    for (int seg = 0; seg < 300; seg++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r <= 5) begin
        s = sec_map[hall];
        if (s == 7) s = 0;
        s = ($urandom_range(0, 1) != 0) ? (s + 1) % 6 : (s + 5) % 6;
        hall = 3'(codes[s]);
      end else if (r == 6) begin
        hall = 3'($urandom_range(0, 7));
      end else if (r == 7) begin
        h = hall;
        hall = 3'($urandom_range(0, 7));
        run_seg(int'($urandom_range(1, 3)), offs, pulses, gchg);
        hall = h;
      end else if (r == 8) begin
        dir = ~dir;
      end else begin
        en = ~en;
      end
      if ($urandom_range(0, 3) == 0) begin
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
      end
      if (!en && $urandom_range(0, 1) == 0) en = 1'b1;
      run_seg(int'($urandom_range(1, 25)), offs, pulses, gchg);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
